// File: rtl/aes_job_sched_if.sv
// Handshake bundle between requesters/consumer, the AES core and the job scheduler.
interface aes_job_sched_if;
    logic req0_valid;
    logic req0_dec;
    logic req0_ready;
    logic req1_valid;
    logic req1_dec;
    logic req1_ready;
    logic load_shift;
    logic unload_en;
    logic staenc;
    logic stadec;
    logic core_done;
    logic rsp_valid;
    logic rsp_id;
    logic rsp_err;
    logic rsp_ready;
    logic busy;

    // Scheduler side.
    modport slave (
        input  req0_valid, req0_dec, req1_valid, req1_dec, core_done, rsp_ready,
        output req0_ready, req1_ready, load_shift, unload_en, staenc, stadec,
               rsp_valid, rsp_id, rsp_err, busy
    );

    // Requester / core / consumer side.
    modport master (
        output req0_valid, req0_dec, req1_valid, req1_dec, core_done, rsp_ready,
        input  req0_ready, req1_ready, load_shift, unload_en, staenc, stadec,
               rsp_valid, rsp_id, rsp_err, busy
    );
endinterface

// File: rtl/aes_job_sched.sv
// Round-robin job scheduler for a single AES core: load, start, run (with timeout),
// unload, then a tagged response. One job in flight at a time.
module aes_job_sched #(
    parameter int LOAD_CYC   = 4,
    parameter int UNLOAD_CYC = 4,
    parameter int TIMEOUT    = 63
) (
    input  logic           clk,
    input  logic           rst,
    aes_job_sched_if.slave bus
);
    localparam int MAX_LU = (LOAD_CYC > UNLOAD_CYC) ? LOAD_CYC : UNLOAD_CYC;
    localparam int MAX_C  = (MAX_LU > TIMEOUT) ? MAX_LU : TIMEOUT;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_UNLOAD = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]    r_state, w_nstate;
    logic [CW-1:0] r_cnt, w_ncnt;
    logic          r_id, w_nid;
    logic          r_dec, w_ndec;
    logic          r_err, w_nerr;
    logic          r_last, w_nlast;
    logic          r_load_shift, r_unload_en, r_staenc, r_stadec, r_rsp_valid, r_busy;
    logic          w_gnt0, w_gnt1;

    // Grant is gated by reset so every output reads 0 while reset is held.
    assign w_gnt0 = rst && (r_state == S_IDLE) && bus.req0_valid && (!bus.req1_valid || r_last);
    assign w_gnt1 = rst && (r_state == S_IDLE) && bus.req1_valid && (!bus.req0_valid || !r_last);

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.load_shift = r_load_shift;
    assign bus.unload_en  = r_unload_en;
    assign bus.staenc     = r_staenc;
    assign bus.stadec     = r_stadec;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_err    = r_err;
    assign bus.busy       = r_busy;

    // Next-state, counter and job-context logic.
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_nid    = r_id;
        w_ndec   = r_dec;
        w_nerr   = r_err;
        w_nlast  = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_gnt0 || w_gnt1) begin
                    w_nid    = w_gnt1;
                    w_ndec   = w_gnt1 ? bus.req1_dec : bus.req0_dec;
                    w_nlast  = w_gnt1;
                    w_ncnt   = '0;
                    w_nstate = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_cnt == CW'(LOAD_CYC - 1)) begin
                    w_ncnt   = '0;
                    w_nstate = S_START;
                end else begin
                    w_ncnt = r_cnt + CW'(1);
                end
            end
            S_START: begin
                w_ncnt   = '0;
                w_nstate = S_RUN;
            end
            S_RUN: begin
                // A completion in the timeout cycle still counts as success.
                if (bus.core_done) begin
                    w_ncnt   = '0;
                    w_nstate = S_UNLOAD;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_ncnt   = '0;
                    w_nerr   = 1'b1;
                    w_nstate = S_RESP;
                end else begin
                    w_ncnt = r_cnt + CW'(1);
                end
            end
            S_UNLOAD: begin
                if (r_cnt == CW'(UNLOAD_CYC - 1)) begin
                    w_ncnt   = '0;
                    w_nstate = S_RESP;
                end else begin
                    w_ncnt = r_cnt + CW'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_nerr   = 1'b0;
                    w_nstate = S_IDLE;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    // State and job context registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_id    <= 1'b0;
            r_dec   <= 1'b0;
            r_err   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_id    <= w_nid;
            r_dec   <= w_ndec;
            r_err   <= w_nerr;
            r_last  <= w_nlast;
        end
    end

    // Outputs registered from the next state so they line up with the state they decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load_shift <= 1'b0;
            r_unload_en  <= 1'b0;
            r_staenc     <= 1'b0;
            r_stadec     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_load_shift <= (w_nstate == S_LOAD) || (w_nstate == S_UNLOAD);
            r_unload_en  <= (w_nstate == S_UNLOAD);
            r_staenc     <= (w_nstate == S_START) && !w_ndec;
            r_stadec     <= (w_nstate == S_START) &&  w_ndec;
            r_rsp_valid  <= (w_nstate == S_RESP);
            r_busy       <= (w_nstate != S_IDLE);
        end
    end
endmodule

// File: tb/tb_aes_job_sched.sv
// Self-checking bench for aes_job_sched: directed table, reset-in-RUN sequence,
// then randomized jobs against a timeline model of each job.
module tb_aes_job_sched;
    localparam int L  = 4;
    localparam int U  = 4;
    localparam int TO = 63;

    logic clk = 1'b0;
    logic rst;
    aes_job_sched_if bus();

    aes_job_sched #(.LOAD_CYC(L), .UNLOAD_CYC(U), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit m_last;

    typedef struct {
        bit v0, v1, d0, d1;
        int r;       // RUN cycle carrying core_done; 0 = never
        int hold;    // cycles rsp_ready stays low once the response is up
        bit exp_id, exp_err;
    } vec_t;

    vec_t tbl[11];

    // {ready0, ready1, load_shift, unload_en, staenc, stadec, rsp_valid, rsp_id, rsp_err, busy}
    function automatic logic [9:0] outs();
        return {bus.req0_ready, bus.req1_ready, bus.load_shift, bus.unload_en, bus.staenc,
                bus.stadec, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.busy};
    endfunction

    task automatic chk(input string nm, input int t, input logic [9:0] act,
                       input logic [9:0] exp, input logic [9:0] mask);
        n_cmp++;
        if ((act & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%b want=%b", nm, t, act & mask, exp & mask);
        end
    endtask

    // Called at a negedge while the DUT is idle. Expected waveform is a function of the
    // cycle offset t from the handshake cycle, derived from the job timeline.
    task automatic job(input string nm, input bit v0, input bit v1, input bit d0, input bit d1,
                       input int r, input int hold, input bit win, input bit err, input bit rnd);
        bit dec;
        int run_end, rsp_start, last_t;
        logic [9:0] e;
        dec       = win ? d1 : d0;
        run_end   = err ? (L + 1 + TO) : (L + 1 + r);
        rsp_start = err ? (run_end + 1) : (run_end + U + 1);
        last_t    = rsp_start + hold;

        bus.req0_valid = v0; bus.req1_valid = v1;
        bus.req0_dec   = d0; bus.req1_dec   = d1;
        bus.core_done  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.rsp_ready  = 1'($urandom_range(0, 1));
        #1;
        e = '0; e[9] = (win == 1'b0); e[8] = (win == 1'b1);
        chk({nm, "_grant"}, 0, outs(), e, 10'b11_1111_1001);
        m_last = win;

        for (int t = 1; t <= last_t; t++) begin
            @(negedge clk);
            #1;
            e    = '0;
            e[7] = (t <= L) || (!err && t > run_end && t <= run_end + U);
            e[6] = !err && t > run_end && t <= run_end + U;
            e[5] = (t == L + 1) && !dec;
            e[4] = (t == L + 1) &&  dec;
            e[3] = (t >= rsp_start);
            e[2] = win;
            e[1] = err;
            e[0] = 1'b1;
            chk(nm, t, outs(), e, e[3] ? 10'h3FF : 10'h3F9);
            if (rnd) begin
                bus.req0_valid = 1'($urandom_range(0, 1));
                bus.req1_valid = 1'($urandom_range(0, 1));
                bus.req0_dec   = 1'($urandom_range(0, 1));
                bus.req1_dec   = 1'($urandom_range(0, 1));
            end
            if (!err && t == L + 1 + r)                bus.core_done = 1'b1;
            else if (t >= L + 2 && t <= run_end)       bus.core_done = 1'b0;
            else                                       bus.core_done = 1'($urandom_range(0, 1));
            if (t == last_t)         bus.rsp_ready = 1'b1;
            else if (t >= rsp_start) bus.rsp_ready = 1'b0;
            else                     bus.rsp_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.core_done  = 1'b0; bus.rsp_ready  = 1'b0;
        #1;
        chk({nm, "_idle"}, last_t + 1, outs(), 10'b0, 10'b11_1111_1001);
    endtask

    initial begin
        // T2 first: both valid out of reset -> 0,1,0,1; then T1, T3, T4 + recovery, T5, T6.
        tbl[0]  = '{1, 1, 0, 1, 10, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 1,  2, 0, 1, 0};
        tbl[2]  = '{1, 1, 1, 0,  5, 1, 0, 0};
        tbl[3]  = '{1, 1, 1, 0,  1, 0, 1, 0};
        tbl[4]  = '{1, 0, 0, 0, 10, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 1,  7, 0, 1, 0};
        tbl[6]  = '{1, 0, 0, 0,  0, 2, 0, 1};
        tbl[7]  = '{0, 1, 0, 0,  3, 0, 1, 0};
        tbl[8]  = '{1, 0, 0, 0, TO, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 1,  5, 20, 1, 0};
        tbl[10] = '{1, 1, 0, 0,  1, 0, 0, 0};

        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.req0_dec   = 1'b0; bus.req1_dec   = 1'b1;
        bus.core_done  = 1'b0; bus.rsp_ready  = 1'b0;
        m_last = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset", 0, outs(), 10'b0, 10'h3FF);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++)
            job($sformatf("vec%0d", i), tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1,
                tbl[i].r, tbl[i].hold, tbl[i].exp_id, tbl[i].exp_err, 1'b0);

        // Reset while RUN: everything drops to 0 and no response ever appears.
        bus.req0_valid = 1'b1; bus.req0_dec = 1'b0;
        for (int t = 1; t <= L + 4; t++) begin
            @(negedge clk);
            bus.req0_valid = 1'b0;
        end
        #1;
        chk("pre_rst_run", L + 4, outs(), 10'b00_0000_0001, 10'h3F9);
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        chk("rst_run", 0, outs(), 10'b0, 10'h3FF);
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        rst = 1'b1;
        m_last = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            bus.core_done = 1'($urandom_range(0, 1));
            bus.rsp_ready = 1'($urandom_range(0, 1));
            #1;
            chk("post_rst", t, outs(), 10'b0, 10'h3FF);
        end
        bus.core_done = 1'b0;

        // Randomized jobs; winner follows round-robin on the bench's own last-grant record.
        for (int k = 0; k < 30; k++) begin
            bit v0, v1, win;
            int r;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            win = (v0 && v1) ? ~m_last : v1;
            r   = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
            job($sformatf("rnd%0d", k), v0, v1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                r, int'($urandom_range(0, 3)), win, (r == 0), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
